// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and select codes for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {RUN, DMISS, SQUASH} ctrl_state_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
    localparam logic [1:0] FWD_RD = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/perf_sat_counter.sv
// perf_sat_counter: event counter that holds at all-ones instead of wrapping.
module perf_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for the 5-stage pipeline with caches.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SRC_WIDTH      = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
    input  logic                      RegWrite_e,
    input  logic [SRC_WIDTH-1:0]      ResultSrc_e,
    input  logic                      PCSrc_e,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_w,
    input  logic                      RegWrite_m,
    input  logic                      RegWrite_w,
    input  logic                      icache_stall,
    input  logic                      dcache_stall,
    output logic                      en_f,
    output logic                      en_fd,
    output logic                      en_de,
    output logic                      en_em,
    output logic                      en_mw,
    output logic                      rst_n_fd,
    output logic                      rst_n_de,
    output logic                      rst_n_em,
    output logic                      rst_n_mw,
    output logic [1:0]                forward_a_e,
    output logic [1:0]                forward_b_e,
    output logic [CNT_WIDTH-1:0]      stall_cnt,
    output logic [CNT_WIDTH-1:0]      flush_cnt
);

    localparam logic [SRC_WIDTH-1:0] LOAD = SRC_WIDTH'(RESULT_SRC_LOAD);

    ctrl_state_e state;
    logic        sq_q;
    logic        sq_mode;
    logic        lu;
    logic        red;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_WIDTH-1:0] rs);
        return (RegWrite_m && Rd_m != '0 && Rd_m == rs) ? FWD_M :
               (RegWrite_w && Rd_w != '0 && Rd_w == rs) ? FWD_W : FWD_RD;
    endfunction

    // sq_q remembers a wrong-path fetch that was outstanding when a D-miss froze the pipe
    assign sq_mode = state == SQUASH || (state == DMISS && sq_q);
    assign lu      = ResultSrc_e == LOAD && RegWrite_e && Rd_e != '0 &&
                     (Rd_e == Rs1_d || Rd_e == Rs2_d);
    assign red     = PCSrc_e;

    assign forward_a_e = rst ? FWD_RD : fwd_sel(Rs1_e);
    assign forward_b_e = rst ? FWD_RD : fwd_sel(Rs2_e);

    always_comb begin
        {en_f, en_fd, en_de, en_em, en_mw} = '1;
        {rst_n_fd, rst_n_de, rst_n_em, rst_n_mw} = '1;
        if (rst) begin
            {rst_n_fd, rst_n_de, rst_n_em, rst_n_mw} = '0;
        end else if (dcache_stall) begin
            {en_f, en_fd, en_de, en_em, en_mw} = '0;
        end else if (red) begin
            rst_n_fd = 1'b0;
            rst_n_de = 1'b0;
        end else if (lu) begin
            en_f     = 1'b0;
            en_fd    = 1'b0;
            rst_n_de = 1'b0;
        end else if (icache_stall) begin
            en_f     = 1'b0;
            rst_n_fd = 1'b0;
        end
        // the word arriving while squashing is from the wrong path, including the final one
        if (!rst && !dcache_stall && sq_mode)
            rst_n_fd = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            sq_q  <= 1'b0;
        end else if (dcache_stall) begin
            state <= DMISS;
            sq_q  <= sq_mode;
        end else begin
            state <= (icache_stall && (red || sq_mode)) ? SQUASH : RUN;
            sq_q  <= 1'b0;
        end
    end

    perf_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!en_f),
        .count (stall_cnt)
    );

    perf_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (!rst_n_de),
        .count (flush_cnt)
    );

endmodule
